// File: rtl/fifo_2d_64to32.sv
// -----------------------------------------------------------------------------
// fifo_2d_64to32
// Width down-converter from 64 to 32 bits, backed by a small circular buffer.
// Each accepted 64-bit word leaves as two 32-bit beats. LO_FIRST picks the
// order: bits [31:0] first, or bits [63:32] first. Both sides use valid/ready.
//
// Optional feature (compile-time macro FIFO_2D_64TO32_HALF_EN):
//   When defined, the a_half port exists and its value is stored with each
//   entry. A half entry emits only its first beat and is then freed.
//
// Ports:
//   clk      in   1   clock, all state updates on posedge
//   rst_n    in   1   asynchronous active-low reset
//   a_data   in   64  incoming word
//   a_valid  in   1   incoming word valid
//   a_ready  out  1   word accepted this cycle when a_valid is also high
//   a_half   in   1   (HALF_EN only) word carries a single beat
//   b_data   out  32  outgoing beat
//   b_valid  out  1   outgoing beat valid
//   b_ready  in   1   consumer takes b_data this cycle
//
// Parameters:
//   DEPTH     number of 64-bit entries (power of two, >= 2)
//   LO_FIRST  1: emit [31:0] then [63:32]; 0: reverse order
// -----------------------------------------------------------------------------
module fifo_2d_64to32 #(
    parameter int DEPTH    = 2,
    parameter bit LO_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] a_data,
    input  logic        a_valid,
    output logic        a_ready,
`ifdef FIFO_2D_64TO32_HALF_EN
    input  logic        a_half,
`endif
    output logic [31:0] b_data,
    output logic        b_valid,
    input  logic        b_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

`ifdef FIFO_2D_64TO32_HALF_EN
    localparam int EW = 65;
`else
    localparam int EW = 64;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          sel;

    logic [EW-1:0] wr_word;
    logic [EW-1:0] head;
    logic          head_half;
    logic [31:0]   first_half;
    logic [31:0]   second_half;
    logic          push;
    logic          beat;
    logic          last;

`ifdef FIFO_2D_64TO32_HALF_EN
    assign wr_word   = {a_half, a_data};
    assign head_half = head[64];
`else
    assign wr_word   = a_data;
    assign head_half = 1'b0;
`endif

    assign head        = mem[rd_ptr];
    assign first_half  = LO_FIRST ? head[31:0]  : head[63:32];
    assign second_half = LO_FIRST ? head[63:32] : head[31:0];

    assign b_valid = (count != '0);
    assign b_data  = sel ? second_half : first_half;

    assign beat = b_valid && b_ready;
    // A half entry has only one beat, so its first beat is also its last.
    assign last = beat && (sel || head_half);

    // When the buffer is full, a word can still be taken in the same cycle
    // the head entry frees. This makes a_ready depend combinationally on
    // b_ready, which is intended.
    assign a_ready = rst_n && ((count != FULL_CNT) || last);
    assign push    = a_valid && a_ready;

    // Storage is not reset. Stale contents are never visible because b_valid
    // is derived from count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            sel    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            if (last) begin
                sel    <= 1'b0;
                rd_ptr <= rd_ptr + AW'(1);
            end else if (beat) begin
                sel    <= 1'b1;
            end

            if (push && !last) begin
                count <= count + CW'(1);
            end else if (last && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule
